// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and defaults for the two-port MemoryUnit bus arbiter.
//   - ADDR_W_DEF / DATA_W_DEF : default bus address / data widths
//   - arb_state_t            : arbiter FSM state encoding
//   - mem_req_t              : one bus request {address, data, we} at default widths
//   - pick_winner            : round-robin winner selection between two requesters
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] address;
    logic [DATA_W_DEF-1:0] data;
    logic                  we;
  } mem_req_t;

  // A lone requester always wins; a tie goes to the port named by prio.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic prio);
    logic win;
    if (req0 && req1) begin
      win = prio;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/bus_req_slot.sv
// bus_req_slot: per-port request holding slot.
//   Captures {address, data, we} on an accepted start, keeps a pend flag until the
//   arbiter takes the request, keeps busy high until completion, and registers the
//   returned read data into q on completion.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   start/address/data/we  : requester inputs (start is a one-cycle pulse)
//   take                   : arbiter grants this port this cycle
//   done, rdata            : this port's transaction completes, with returned data
//   busy, q                : registered status / read data back to the requester
//   req_valid, req_*       : request offered to the arbiter (held or live)
module bus_req_slot
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  input  logic              take,
  input  logic              done,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] q,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_address,
  output logic [DATA_W-1:0] req_data,
  output logic              req_we
);

  logic              accept_s;
  logic              pend_r;
  logic              busy_r;
  logic [ADDR_W-1:0] hold_address_r;
  logic [DATA_W-1:0] hold_data_r;
  logic              hold_we_r;
  logic [DATA_W-1:0] q_r;

  // A start while busy is a protocol violation and is dropped here.
  assign accept_s  = start & ~busy_r;
  assign req_valid = pend_r | accept_s;
  assign busy      = busy_r;
  assign q         = q_r;

  // Offer the held request, or the live inputs when the port starts this very cycle.
  always_comb begin
    req_address = hold_address_r;
    req_data    = hold_data_r;
    req_we      = hold_we_r;
    if (pend_r) begin
      req_address = hold_address_r;
      req_data    = hold_data_r;
      req_we      = hold_we_r;
    end else begin
      req_address = address;
      req_data    = data;
      req_we      = we;
    end
  end

  // Holding register, pend/busy flags and returned data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r         <= 1'b0;
      busy_r         <= 1'b0;
      hold_address_r <= {ADDR_W{1'b0}};
      hold_data_r    <= {DATA_W{1'b0}};
      hold_we_r      <= 1'b0;
      q_r            <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        hold_address_r <= address;
        hold_data_r    <= data;
        hold_we_r      <= we;
      end
      // take wins over accept: a request granted on its start cycle never pends.
      if (take) begin
        pend_r <= 1'b0;
      end else if (accept_s) begin
        pend_r <= 1'b1;
      end
      // done and accept are exclusive because done only happens while busy.
      if (done) begin
        busy_r <= 1'b0;
        q_r    <= rdata;
      end else if (accept_s) begin
        busy_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single MemoryUnit bus between port 0 (CPU) and
// port 1 (DMA/copy engine), one queued request per port, round-robin grants,
// read data routed back to the owning port. No grant before m_initDone.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   sN_address/sN_data/sN_we/sN_start : requester N request (start = 1-cycle pulse)
//   sN_busy, sN_q                   : requester N status and returned data
//   m_address/m_data/m_we/m_start   : to MemoryUnit (start = 1-cycle pulse)
//   m_busy, m_q, m_initDone         : from MemoryUnit
//   grant                           : port currently owning the bus (debug)
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_we,
  input  logic              s0_start,
  output logic              s0_busy,
  output logic [DATA_W-1:0] s0_q,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_we,
  input  logic              s1_start,
  output logic              s1_busy,
  output logic [DATA_W-1:0] s1_q,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data,
  output logic              m_we,
  output logic              m_start,
  input  logic              m_busy,
  input  logic [DATA_W-1:0] m_q,
  input  logic              m_initDone,
  output logic              grant
);

  arb_state_t        state_r;
  logic              prio_r;
  logic              grant_r;
  logic              m_start_r;
  logic              m_we_r;
  logic [ADDR_W-1:0] m_address_r;
  logic [DATA_W-1:0] m_data_r;

  logic              req_valid0_s, req_valid1_s;
  logic [ADDR_W-1:0] req_address0_s, req_address1_s;
  logic [DATA_W-1:0] req_data0_s, req_data1_s;
  logic              req_we0_s, req_we1_s;

  logic              fire_s;
  logic              winner_s;
  logic              done_s;
  logic [ADDR_W-1:0] win_address_s;
  logic [DATA_W-1:0] win_data_s;
  logic              win_we_s;

  assign fire_s   = (state_r == ST_IDLE) & m_initDone & (req_valid0_s | req_valid1_s);
  assign winner_s = pick_winner(req_valid0_s, req_valid1_s, prio_r);
  assign done_s   = (state_r == ST_WAIT_LO) & ~m_busy;

  assign m_address = m_address_r;
  assign m_data    = m_data_r;
  assign m_we      = m_we_r;
  assign m_start   = m_start_r;
  assign grant     = grant_r;

  bus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk         (clk),
    .reset       (reset),
    .start       (s0_start),
    .address     (s0_address),
    .data        (s0_data),
    .we          (s0_we),
    .take        (fire_s & ~winner_s),
    .done        (done_s & ~grant_r),
    .rdata       (m_q),
    .busy        (s0_busy),
    .q           (s0_q),
    .req_valid   (req_valid0_s),
    .req_address (req_address0_s),
    .req_data    (req_data0_s),
    .req_we      (req_we0_s)
  );

  bus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk         (clk),
    .reset       (reset),
    .start       (s1_start),
    .address     (s1_address),
    .data        (s1_data),
    .we          (s1_we),
    .take        (fire_s & winner_s),
    .done        (done_s & grant_r),
    .rdata       (m_q),
    .busy        (s1_busy),
    .q           (s1_q),
    .req_valid   (req_valid1_s),
    .req_address (req_address1_s),
    .req_data    (req_data1_s),
    .req_we      (req_we1_s)
  );

  // Request of the port about to be granted.
  always_comb begin
    win_address_s = req_address0_s;
    win_data_s    = req_data0_s;
    win_we_s      = req_we0_s;
    if (winner_s) begin
      win_address_s = req_address1_s;
      win_data_s    = req_data1_s;
      win_we_s      = req_we1_s;
    end else begin
      win_address_s = req_address0_s;
      win_data_s    = req_data0_s;
      win_we_s      = req_we0_s;
    end
  end

  // Arbiter FSM: grant, single-cycle m_start, then follow the MemoryUnit busy handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      prio_r      <= 1'b0;
      grant_r     <= 1'b0;
      m_start_r   <= 1'b0;
      m_we_r      <= 1'b0;
      m_address_r <= {ADDR_W{1'b0}};
      m_data_r    <= {DATA_W{1'b0}};
    end else begin
      m_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fire_s) begin
            m_address_r <= win_address_s;
            m_data_r    <= win_data_s;
            m_we_r      <= win_we_s;
            grant_r     <= winner_s;
            m_start_r   <= 1'b1;
            state_r     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (m_busy) begin
            state_r <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          // Completion: the port not just served gets the next tie.
          if (!m_busy) begin
            prio_r  <= ~grant_r;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized and directed stimulus against a transaction-level
// model of the arbiter (per-port outstanding requests, round-robin rule, expected
// read data) plus a behavioural MemoryUnit with variable busy latency.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW = 27;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] s0_address = '0, s1_address = '0;
  logic [DW-1:0] s0_data = '0, s1_data = '0;
  logic          s0_we = 1'b0, s1_we = 1'b0, s0_start = 1'b0, s1_start = 1'b0;
  logic          s0_busy, s1_busy;
  logic [DW-1:0] s0_q, s1_q;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data;
  logic          m_we, m_start;
  logic          m_busy = 1'b0;
  logic [DW-1:0] m_q = '0;
  logic          m_initDone = 1'b0;
  logic          grant;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_data(s0_data), .s0_we(s0_we), .s0_start(s0_start),
    .s0_busy(s0_busy), .s0_q(s0_q),
    .s1_address(s1_address), .s1_data(s1_data), .s1_we(s1_we), .s1_start(s1_start),
    .s1_busy(s1_busy), .s1_q(s1_q),
    .m_address(m_address), .m_data(m_data), .m_we(m_we), .m_start(m_start),
    .m_busy(m_busy), .m_q(m_q), .m_initDone(m_initDone), .grant(grant)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model state.
  bit            mdl_out [2];   // request accepted, not yet completed
  bit            mdl_iss [2];   // request already put on the bus
  mem_req_t      mdl_req [2];
  logic [DW-1:0] mdl_q   [2];
  bit            mdl_prio;
  bit            bus_busy;
  bit            bus_owner;
  bit            exp_fire;
  bit            exp_win;
  bit            cmp_pend;
  bit            cmp_port;
  logic [DW-1:0] cmp_val;
  bit            rst_prev = 1'b1;
  bit            init_lvl = 1'b0;
  int            grant_log [$];
  int            sub_cnt [2];

  // Behavioural MemoryUnit.
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            mu_active;
  int            mu_step, mu_lat;
  int            lat_cfg = 0;       // 0 selects a random latency per transaction
  logic [DW-1:0] mu_ret;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {5'd0, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r.address = 27'h100 + 27'($urandom_range(0, 7));
    r.data    = $urandom;
    r.we      = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic mem_req_t mk_req(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    mem_req_t r;
    r.address = a;
    r.data    = d;
    r.we      = w;
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mdl_out[p] = 1'b0;
      mdl_iss[p] = 1'b0;
      mdl_q[p]   = '0;
    end
    mdl_prio  = 1'b0;
    bus_busy  = 1'b0;
    exp_fire  = 1'b0;
    cmp_pend  = 1'b0;
    mu_active = 1'b0;
  endtask

  // One clock: observe and check after the edge, then drive inputs for the next edge.
  task automatic tick(input bit go0, input mem_req_t r0, input bit go1, input mem_req_t r1, input bit rst);
    bit       go [2];
    mem_req_t rq [2];
    bit       c0, c1;
    go[0] = go0; go[1] = go1; rq[0] = r0; rq[1] = r1;
    @(posedge clk);
    #1;
    if (rst_prev) begin
      model_reset();
      check_val("rst_grant", 32'(grant), 32'd0);
      check_val("rst_m_address", 32'(m_address), 32'd0);
      check_val("rst_m_data", m_data, 32'd0);
      check_val("rst_m_we", 32'(m_we), 32'd0);
    end else if (cmp_pend) begin
      mdl_out[cmp_port] = 1'b0;
      mdl_iss[cmp_port] = 1'b0;
      mdl_q[cmp_port]   = cmp_val;
      mdl_prio          = ~cmp_port;
      bus_busy          = 1'b0;
      cmp_pend          = 1'b0;
    end
    check_val("s0_busy", 32'(s0_busy), 32'(mdl_out[0]));
    check_val("s1_busy", 32'(s1_busy), 32'(mdl_out[1]));
    check_val("s0_q", s0_q, mdl_q[0]);
    check_val("s1_q", s1_q, mdl_q[1]);
    check_val("m_start", 32'(m_start), 32'(exp_fire));
    if (exp_fire) begin
      check_val("grant", 32'(grant), 32'(exp_win));
      check_val("m_address", 32'(m_address), 32'(mdl_req[exp_win].address));
      check_val("m_data", m_data, mdl_req[exp_win].data);
      check_val("m_we", 32'(m_we), 32'(mdl_req[exp_win].we));
      grant_log.push_back(int'(exp_win));
      mdl_iss[exp_win] = 1'b1;
      bus_busy  = 1'b1;
      bus_owner = exp_win;
      mu_active = 1'b1;
      mu_step   = -1;
      mu_lat    = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 4);
      if (mdl_req[exp_win].we) begin
        mem[mdl_req[exp_win].address] = mdl_req[exp_win].data;
        mu_ret = ~mdl_req[exp_win].data;
      end else begin
        mu_ret = mem_read(mdl_req[exp_win].address);
      end
    end
    // MemoryUnit: idle on the issue cycle, busy for mu_lat cycles, then data with busy low.
    m_q = $urandom;
    if (rst) begin
      m_busy = 1'b0;
      mu_active = 1'b0;
    end else if (mu_active) begin
      mu_step++;
      if (mu_step == 0) begin
        m_busy = 1'b0;
      end else if (mu_step <= mu_lat) begin
        m_busy = 1'b1;
      end else begin
        m_busy    = 1'b0;
        m_q       = mu_ret;
        cmp_pend  = 1'b1;
        cmp_port  = bus_owner;
        cmp_val   = mu_ret;
        mu_active = 1'b0;
      end
    end else begin
      m_busy = 1'b0;
    end
    // Requesters: a start on a port that is still busy must be ignored.
    s0_start = 1'b0; s1_start = 1'b0;
    s0_address = 27'($urandom); s0_data = $urandom; s0_we = 1'($urandom_range(0, 1));
    s1_address = 27'($urandom); s1_data = $urandom; s1_we = 1'($urandom_range(0, 1));
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (go[p]) begin
          if (p == 0) begin
            s0_start = 1'b1; s0_address = rq[p].address; s0_data = rq[p].data; s0_we = rq[p].we;
          end else begin
            s1_start = 1'b1; s1_address = rq[p].address; s1_data = rq[p].data; s1_we = rq[p].we;
          end
          if (!mdl_out[p]) begin
            mdl_out[p] = 1'b1;
            mdl_iss[p] = 1'b0;
            mdl_req[p] = rq[p];
            sub_cnt[p]++;
          end
        end
      end
    end
    m_initDone = init_lvl;
    c0 = mdl_out[0] && !mdl_iss[0];
    c1 = mdl_out[1] && !mdl_iss[1];
    exp_fire = !rst && !bus_busy && init_lvl && (c0 || c1);
    exp_win  = (c0 && c1) ? mdl_prio : c1;
    reset    = rst;
    rst_prev = rst;
  endtask

  task automatic idle_tick();
    tick(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    bit settled = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus_busy && !mdl_out[0] && !mdl_out[1] && !cmp_pend && !exp_fire) begin
        settled = 1'b1;
        break;
      end
      idle_tick();
    end
    check_val("drain_timeout", 32'(settled), 32'd1);
  endtask

  initial begin
    // Reset, then initDone gating: s1 starts at cycle 5 with initDone low for 50 cycles.
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      tick(1'b0, '0, (c == 5), mk_req(27'h0000400, 32'h0, 1'b0), 1'b0);
    end
    init_lvl = 1'b1;
    drain();

    // Single read on port 0 with a three-cycle busy.
    mem[27'h0000100] = 32'hDEADBEEF;
    lat_cfg = 3;
    tick(1'b1, mk_req(27'h0000100, 32'h0, 1'b0), 1'b0, '0, 1'b0);
    drain();
    check_val("single_read_q", s0_q, 32'hDEADBEEF);

    // Simultaneous starts straight after reset: port 0 wins the tie.
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    grant_log.delete();
    tick(1'b1, mk_req(27'h0000200, 32'h11111111, 1'b1), 1'b1, mk_req(27'h0000300, 32'h0, 1'b0), 1'b0);
    drain();
    check_val("simul_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check_val("simul_first", 32'(grant_log[0]), 32'd0);
      check_val("simul_second", 32'(grant_log[1]), 32'd1);
    end

    // Fairness: both ports restart on every busy fall, 10 transactions each.
    lat_cfg = 0;
    grant_log.delete();
    sub_cnt[0] = 0; sub_cnt[1] = 0;
    for (int i = 0; i < 400; i++) begin
      if (sub_cnt[0] >= 10 && sub_cnt[1] >= 10) break;
      tick(!mdl_out[0] && sub_cnt[0] < 10, rand_req(), !mdl_out[1] && sub_cnt[1] < 10, rand_req(), 1'b0);
    end
    drain();
    check_val("fair_count", 32'(grant_log.size()), 32'd20);
    for (int i = 0; i < grant_log.size(); i++) begin
      check_val("fair_alternate", 32'(grant_log[i]), 32'(i % 2));
    end

    // Protocol violation: a second start on a busy port must not replace its request.
    lat_cfg = 4;
    tick(1'b0, '0, 1'b1, mk_req(27'h0000500, 32'h0, 1'b0), 1'b0);
    tick(1'b1, mk_req(27'h0000600, 32'h12345678, 1'b1), 1'b0, '0, 1'b0);
    tick(1'b1, mk_req(27'h0000700, 32'h87654321, 1'b1), 1'b0, '0, 1'b0);
    drain();
    check_val("violation_mem", mem_read(27'h0000600), 32'h12345678);

    // Random traffic, including starts on busy ports.
    lat_cfg = 0;
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 2) == 0, rand_req(), $urandom_range(0, 2) == 0, rand_req(), 1'b0);
    end
    drain();

    // Reset while in WAIT_LO with port 1 pending.
    lat_cfg = 4;
    tick(1'b1, mk_req(27'h0000100, 32'h0, 1'b0), 1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b1, mk_req(27'h0000101, 32'h0, 1'b0), 1'b0);
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (mu_active && mu_step >= 2) begin
          reached = 1'b1;
          break;
        end
        idle_tick();
      end
      check_val("rst_setup", 32'(reached), 32'd1);
    end
    check_val("rst_setup_pend1", 32'(mdl_out[1]), 32'd1);
    tick(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      idle_tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
